ebox_ebus_hub: RTL and testbench

- EBOX-side EBUS data multiplexer and bus monitor.
- Selects which of the twelve EBOX sub-module drivers owns the 36-bit EBUS data lines: APR, CON, CRA, CTL, EDP, IR, MBZ, MTR, PIC, SCD, SHM, VMA.
- Supplies a registered copy of the bus, detects multi-driver contention, and publishes the fixed APR hardware-options word.
- Sits between the EBOX sub-modules and the shared EBUS consumers (RH20/DTE20 side).

---
 rtl/ebox_ebus_hub.sv | 92 +++++++++
 tb/tb_ebox_ebus_hub.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ebox_ebus_hub.sv
// EBOX-side EBUS data multiplexer: fixed-priority driver select, registered
// bus copy, sticky multi-driver contention monitor and APR options word.
module ebox_ebus_hub #(
  parameter int unsigned W        = 36,
  parameter int unsigned NSRC     = 12,
  parameter logic [12:0] SERIAL   = 13'd4001,
  parameter logic        OPT50HZ  = 1'b0,
  parameter logic        OPTCACHE = 1'b0,
  parameter logic        OPTINTCH = 1'b1,
  parameter logic        OPTXKL   = 1'b1,
  parameter logic        OPTMOSC  = 1'b0
) (
  input  logic              clk,
  input  logic              CROBAR,
  input  logic [NSRC-1:0]   driving,
  input  logic [NSRC*W-1:0] drv_data,
  input  logic              clr_err,
  output logic [W-1:0]      ebus_data,
  output logic [W-1:0]      ebus_data_q,
  output logic [3:0]        ebus_src_q,
  output logic              ebus_busy_q,
  output logic              contention,
  output logic [7:0]        contention_cnt,
  output logic [17:0]       hw_options
);

  logic [W-1:0] sel_data;
  logic [3:0]   sel_src;
  logic [4:0]   n_drv;
  logic         multi;

  logic [W-1:0] ebus_data_d;
  logic [3:0]   ebus_src_d;
  logic         ebus_busy_d;
  logic         contention_q, contention_d;
  logic [7:0]   contention_cnt_q, contention_cnt_d;

  // Scan from highest index down so the lowest-indexed driver wins last;
  // unselected slices never reach the result.
  always_comb begin
    sel_data = '0;
    sel_src  = 4'hF;
    n_drv    = '0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (driving[i-1]) begin
        sel_data = drv_data[(i-1)*W +: W];
        sel_src  = 4'(i-1);
        n_drv    = n_drv + 5'd1;
      end
    end
    multi = (n_drv >= 5'd2);
  end

  assign ebus_data = sel_data;

  always_comb begin
    ebus_data_d      = sel_data;
    ebus_src_d       = sel_src;
    ebus_busy_d      = |driving;
    contention_d     = contention_q;
    contention_cnt_d = contention_cnt_q;
    if (clr_err) begin
      contention_d     = 1'b0;
      contention_cnt_d = '0;
    end else if (multi) begin
      contention_d = 1'b1;
      if (contention_cnt_q != 8'hFF)
        contention_cnt_d = contention_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!CROBAR) begin
      ebus_data_q      <= '0;
      ebus_src_q       <= 4'hF;
      ebus_busy_q      <= 1'b0;
      contention_q     <= 1'b0;
      contention_cnt_q <= '0;
    end else begin
      ebus_data_q      <= ebus_data_d;
      ebus_src_q       <= ebus_src_d;
      ebus_busy_q      <= ebus_busy_d;
      contention_q     <= contention_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign contention     = contention_q;
  assign contention_cnt = contention_cnt_q;
  assign hw_options     = {OPT50HZ, OPTCACHE, OPTINTCH, OPTXKL, OPTMOSC, SERIAL};

endmodule

// File: tb/tb_ebox_ebus_hub.sv
// Bench for ebox_ebus_hub: directed scenarios plus random traffic, checked
// against a cycle-level behavioural model of the bus hub.
module tb_ebox_ebus_hub;

  logic         clk = 1'b0;
  logic         crobar;
  logic [11:0]  driving;
  logic [431:0] drv_data;
  logic         clr_err;
  logic [35:0]  ebus_data, ebus_data_q;
  logic [3:0]   ebus_src_q;
  logic         ebus_busy_q, contention;
  logic [7:0]   contention_cnt;
  logic [17:0]  hw_options;

  logic [35:0] src_data [12];

  // model state
  logic [35:0] m_data;
  int          m_src, m_cnt;
  logic        m_busy, m_cont;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ebox_ebus_hub dut (
    .clk(clk), .CROBAR(crobar), .driving(driving), .drv_data(drv_data),
    .clr_err(clr_err), .ebus_data(ebus_data), .ebus_data_q(ebus_data_q),
    .ebus_src_q(ebus_src_q), .ebus_busy_q(ebus_busy_q),
    .contention(contention), .contention_cnt(contention_cnt),
    .hw_options(hw_options)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_src();
    for (int i = 0; i < 12; i++) if (driving[i]) return i;
    return -1;
  endfunction

  function automatic logic [35:0] exp_bus();
    int s = first_src();
    return (s < 0) ? 36'd0 : src_data[s];
  endfunction

  // One clock: check combinational bus, advance model at the edge, check registers.
  task automatic cyc();
    for (int i = 0; i < 12; i++) drv_data[i*36 +: 36] = src_data[i];
    #1;
    chk("ebus_data", ebus_data, exp_bus());
    @(posedge clk);
    if (!crobar) begin
      m_data = '0; m_src = 15; m_busy = 0; m_cont = 0; m_cnt = 0;
    end else begin
      m_data = exp_bus();
      m_src  = (first_src() < 0) ? 15 : first_src();
      m_busy = (driving != 0);
      if (clr_err) begin
        m_cont = 0; m_cnt = 0;
      end else if ($countones(driving) >= 2) begin
        m_cont = 1;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
    #1;
    chk("ebus_data_q", ebus_data_q, m_data);
    chk("ebus_src_q", 36'(ebus_src_q), 36'(m_src));
    chk("ebus_busy_q", 36'(ebus_busy_q), 36'(m_busy));
    chk("contention", 36'(contention), 36'(m_cont));
    chk("contention_cnt", 36'(contention_cnt), 36'(m_cnt));
  endtask

  task automatic rand_data();
    for (int i = 0; i < 12; i++) src_data[i] = 36'({$urandom(), $urandom()});
  endtask

  initial begin
    m_data = '0; m_src = 15; m_busy = 0; m_cont = 0; m_cnt = 0;
    crobar = 1'b0; clr_err = 1'b0; driving = 12'hFFF;
    rand_data();

    // reset with every source driving, clr_err also asserted
    cyc();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("hw_options", 36'(hw_options), 36'((18'd1 << 15) | (18'd1 << 14) | 18'd4001));

    // single EDP driver
    crobar = 1'b1;
    driving = 12'h010;
    src_data[4] = 36'o123456701234;
    cyc();
    chk("edp_src", 36'(ebus_src_q), 36'd4);
    chk("edp_data_q", ebus_data_q, 36'o123456701234);

    // idle with nonzero data everywhere
    driving = '0;
    for (int i = 0; i < 12; i++) src_data[i] = 36'o777000777000 + 36'(i);
    cyc();

    // CON + VMA contention for 3 cycles
    driving = 12'h802;
    src_data[1] = 36'o1;
    src_data[11] = 36'o2;
    repeat (3) cyc();
    chk("cont_cnt3", 36'(contention_cnt), 36'd3);
    chk("cont_src", 36'(ebus_src_q), 36'd1);

    // saturation then clear while contention persists
    repeat (300) cyc();
    chk("cnt_sat", 36'(contention_cnt), 36'hFF);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("clr_cnt", 36'(contention_cnt), 36'd0);
    chk("clr_flag", 36'(contention), 36'd0);

    // walk every source singly
    for (int i = 0; i < 12; i++) src_data[i] = 36'(i + 1);
    for (int i = 0; i < 12; i++) begin
      driving = 12'(1 << i);
      cyc();
      chk("walk_data_q", ebus_data_q, 36'(i + 1));
      chk("walk_src_q", 36'(ebus_src_q), 36'(i));
      if (i == 6) begin
        crobar = 1'b0;
        cyc();
        chk("midwalk_rst", ebus_data_q, 36'd0);
        crobar = 1'b1;
      end
    end

    // random traffic: mostly sparse drivers, occasional clear and reset
    for (int n = 0; n < 400; n++) begin
      rand_data();
      case ($urandom_range(0, 3))
        0: driving = '0;
        1: driving = 12'(1 << $urandom_range(0, 11));
        2: driving = 12'((1 << $urandom_range(0, 11)) | (1 << $urandom_range(0, 11)));
        default: driving = 12'($urandom());
      endcase
      clr_err = ($urandom_range(0, 15) == 0);
      crobar  = ($urandom_range(0, 31) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
